// File: rtl/lsu_mem_master_pkg.sv
// Shared size codes, FSM states and lane-mask helper for the MEM-stage data-RAM master.
package lsu_mem_master_pkg;

    localparam logic [1:0] MEM_BYTE     = 2'd0;
    localparam logic [1:0] MEM_HALF     = 2'd1;
    localparam logic [1:0] MEM_WORD     = 2'd2;
    localparam logic [3:0] BYTE_SEL_ALL = 4'b1111;

    typedef enum logic [0:0] {
        LSU_IDLE   = 1'b0,
        LSU_SECOND = 1'b1
    } lsu_state_e;

    // Reserved size code 3 falls through to the full-word mask.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        logic [3:0] mask;
        case (size)
            MEM_BYTE: mask = 4'b0001;
            MEM_HALF: mask = 4'b0011;
            default:  mask = BYTE_SEL_ALL;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/lsu_mem_master_align.sv
// Load-path lane shifter: moves the addressed bytes to bit 0, then sign/zero-extends by size.
module mem_lane_align
    import lsu_mem_master_pkg::*;
(
    input  logic [31:0] raw_data,
    input  logic [1:0]  lane_off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] shifted,
    output logic [31:0] ext_data
);

    // Right-justify and extend
    always_comb begin
        shifted = raw_data >> {lane_off, 3'b000};
        case (size)
            MEM_BYTE: ext_data = is_unsigned ? {24'h000000, shifted[7:0]}
                                             : {{24{shifted[7]}}, shifted[7:0]};
            MEM_HALF: ext_data = is_unsigned ? {16'h0000, shifted[15:0]}
                                             : {{16{shifted[15]}}, shifted[15:0]};
            default:  ext_data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// MEM-stage data-RAM initiator: byte/half/word loads and stores on a 4-lane byte-select RAM,
// with word-straddling accesses either split into two bus cycles or rejected.
module lsu_mem_master
    import lsu_mem_master_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int MISALIGN_SPLIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              stall_req,
    output logic              err,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_sel,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    lsu_state_e        state_q, state_d;
    logic [31:0]       hold_q, hold_d;

    logic [1:0]        off_s;
    logic [7:0]        sel_wide_s;
    logic              straddle_s;
    logic [2:0]        inv_off_s;
    logic [ADDR_W-1:0] lo_addr_s;
    logic [ADDR_W-1:0] hi_addr_s;
    logic [31:0]       merged_s;
    logic [31:0]       align_raw_s;
    logic [1:0]        align_off_s;
    logic [31:0]       shifted_s;
    logic [31:0]       ext_s;

    // Lanes that spill past bit 3 of the shifted mask belong to the next word.
    assign off_s      = req_addr[1:0];
    assign sel_wide_s = {4'b0000, size_mask(req_size)} << off_s;
    assign straddle_s = |sel_wide_s[7:4];
    assign inv_off_s  = 3'd4 - {1'b0, off_s};
    assign lo_addr_s  = {req_addr[ADDR_W-1:2], 2'b00};
    assign hi_addr_s  = lo_addr_s + {{(ADDR_W-3){1'b0}}, 3'b100};
    assign merged_s   = hold_q | (ram_rdata << {inv_off_s, 3'b000});

    // The second half is already merged at lane 0, so it needs no further shift.
    assign align_raw_s = (state_q == LSU_SECOND) ? merged_s : ram_rdata;
    assign align_off_s = (state_q == LSU_SECOND) ? 2'b00 : off_s;

    mem_lane_align u_align (
        .raw_data    (align_raw_s),
        .lane_off    (align_off_s),
        .size        (req_size),
        .is_unsigned (req_unsigned),
        .shifted     (shifted_s),
        .ext_data    (ext_s)
    );

    // Next-state and bus-cycle decode
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        ram_ce    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = {ADDR_W{1'b0}};
        ram_sel   = 4'b0000;
        ram_wdata = 32'h0000_0000;
        rdata     = 32'h0000_0000;
        done      = 1'b0;
        stall_req = 1'b0;
        err       = 1'b0;
        if (rst) begin
            state_d = LSU_IDLE;
            hold_d  = 32'h0000_0000;
        end else begin
            case (state_q)
                LSU_IDLE: begin
                    if (req_valid && !straddle_s) begin
                        ram_ce    = 1'b1;
                        ram_we    = req_we;
                        ram_addr  = lo_addr_s;
                        ram_sel   = sel_wide_s[3:0];
                        ram_wdata = req_wdata << {off_s, 3'b000};
                        done      = 1'b1;
                        rdata     = req_we ? 32'h0000_0000 : ext_s;
                    end else if (req_valid && (MISALIGN_SPLIT != 0)) begin
                        ram_ce    = 1'b1;
                        ram_we    = req_we;
                        ram_addr  = lo_addr_s;
                        ram_sel   = sel_wide_s[3:0];
                        ram_wdata = req_wdata << {off_s, 3'b000};
                        stall_req = 1'b1;
                        hold_d    = req_we ? hold_q : shifted_s;
                        state_d   = LSU_SECOND;
                    end else if (req_valid) begin
                        err  = 1'b1;
                        done = 1'b1;
                    end else begin
                        state_d = LSU_IDLE;
                    end
                end
                LSU_SECOND: begin
                    // A dropped request abandons the second half; the first half stays written.
                    if (req_valid) begin
                        ram_ce    = 1'b1;
                        ram_we    = req_we;
                        ram_addr  = hi_addr_s;
                        ram_sel   = sel_wide_s[7:4];
                        ram_wdata = req_wdata >> {inv_off_s, 3'b000};
                        done      = 1'b1;
                        rdata     = req_we ? 32'h0000_0000 : ext_s;
                    end else begin
                        done = 1'b0;
                    end
                    state_d = LSU_IDLE;
                end
                default: state_d = LSU_IDLE;
            endcase
        end
    end

    // State and load-hold registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LSU_IDLE;
            hold_q  <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench: one splitting and one rejecting instance, each on its own 16-word RAM model.
module tb_lsu_mem_master;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic [31:0] rdata1, rdata2;
    logic        done1, done2, stall1, stall2, err1, err2;
    logic        ram_ce1, ram_ce2, ram_we1, ram_we2;
    logic [31:0] ram_addr1, ram_addr2;
    logic [3:0]  ram_sel1, ram_sel2;
    logic [31:0] ram_wdata1, ram_wdata2;
    logic [31:0] ram_rdata1, ram_rdata2;

    logic [31:0] mem1 [16];
    logic [31:0] mem2 [16];
    logic        pl_we;
    logic [3:0]  pl_idx;
    logic [31:0] pl_data;

    int checks   = 0;
    int failures = 0;

    lsu_mem_master #(.ADDR_W(32), .MISALIGN_SPLIT(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .rdata(rdata1), .done(done1), .stall_req(stall1), .err(err1),
        .ram_ce(ram_ce1), .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_sel(ram_sel1),
        .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1)
    );

    lsu_mem_master #(.ADDR_W(32), .MISALIGN_SPLIT(0)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .rdata(rdata2), .done(done2), .stall_req(stall2), .err(err2),
        .ram_ce(ram_ce2), .ram_we(ram_we2), .ram_addr(ram_addr2), .ram_sel(ram_sel2),
        .ram_wdata(ram_wdata2), .ram_rdata(ram_rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word address 0xFFFFFFFC aliases index 15; the bench never uses 0x3C.
    assign ram_rdata1 = mem1[ram_addr1[5:2]];
    assign ram_rdata2 = mem2[ram_addr2[5:2]];

    always @(posedge clk) begin
        if (pl_we) begin
            mem1[pl_idx] <= pl_data;
            mem2[pl_idx] <= pl_data;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (ram_ce1 && ram_we1 && ram_sel1[i])
                    mem1[ram_addr1[5:2]][8*i +: 8] <= ram_wdata1[8*i +: 8];
                if (ram_ce2 && ram_we2 && ram_sel2[i])
                    mem2[ram_addr2[5:2]][8*i +: 8] <= ram_wdata2[8*i +: 8];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid    = v;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] data);
        pl_we   = 1'b1;
        pl_idx  = idx;
        pl_data = data;
        next_cycle();
        pl_we   = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        pl_we = 1'b0;
        pl_idx = 4'd0;
        pl_data = 32'h0;
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);

        @(negedge clk);
        check_eq("rst_ce",    32'(ram_ce1),  32'h0);
        check_eq("rst_we",    32'(ram_we1),  32'h0);
        check_eq("rst_addr",  ram_addr1,     32'h0);
        check_eq("rst_sel",   32'(ram_sel1), 32'h0);
        check_eq("rst_wdata", ram_wdata1,    32'h0);
        check_eq("rst_rdata", rdata1,        32'h0);
        check_eq("rst_done",  32'(done1),    32'h0);
        check_eq("rst_stall", 32'(stall1),   32'h0);
        check_eq("rst_err",   32'(err2),     32'h0);
        next_cycle();
        rst = 1'b0;

        preload(4'd4,  32'h0000_0000);
        preload(4'd8,  32'h8001_1234);
        preload(4'd1,  32'hAAAA_AAAA);
        preload(4'd2,  32'hBBBB_BBBB);
        preload(4'd15, 32'hBEEF_1111);
        preload(4'd0,  32'h2222_CAFE);

        // SB to the top lane
        drive(1'b1, 1'b1, 2'd0, 1'b0, 32'h13, 32'hAB);
        @(negedge clk);
        check_eq("sb_addr",  ram_addr1,     32'h10);
        check_eq("sb_sel",   32'(ram_sel1), 32'h8);
        check_eq("sb_wdata", ram_wdata1,    32'hAB00_0000);
        check_eq("sb_done",  32'(done1),    32'h1);
        check_eq("sb_stall", 32'(stall1),   32'h0);
        check_eq("sb_we",    32'(ram_we1),  32'h1);
        next_cycle();
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        check_eq("sb_mem", mem1[4], 32'hAB00_0000);

        // Half and byte loads, signed and unsigned
        drive(1'b1, 1'b0, 2'd1, 1'b0, 32'h22, 32'h0);
        @(negedge clk);
        check_eq("lh_rdata", rdata1, 32'hFFFF_8001);
        check_eq("lh_done",  32'(done1), 32'h1);
        next_cycle();
        drive(1'b1, 1'b0, 2'd1, 1'b1, 32'h22, 32'h0);
        @(negedge clk);
        check_eq("lhu_rdata", rdata1, 32'h0000_8001);
        next_cycle();
        drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h23, 32'h0);
        @(negedge clk);
        check_eq("lb_rdata", rdata1, 32'hFFFF_FF80);
        next_cycle();
        drive(1'b1, 1'b0, 2'd0, 1'b1, 32'h20, 32'h0);
        @(negedge clk);
        check_eq("lbu_rdata", rdata1, 32'h0000_0034);
        next_cycle();

        // Split SW across words 0x04/0x08
        drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h06, 32'h1122_3344);
        @(negedge clk);
        check_eq("sw_c0_addr",  ram_addr1,     32'h04);
        check_eq("sw_c0_sel",   32'(ram_sel1), 32'hC);
        check_eq("sw_c0_wdata", ram_wdata1,    32'h3344_0000);
        check_eq("sw_c0_stall", 32'(stall1),   32'h1);
        check_eq("sw_c0_done",  32'(done1),    32'h0);
        next_cycle();
        @(negedge clk);
        check_eq("sw_c1_addr",  ram_addr1,     32'h08);
        check_eq("sw_c1_sel",   32'(ram_sel1), 32'h3);
        check_eq("sw_c1_wdata", ram_wdata1,    32'h0000_1122);
        check_eq("sw_c1_done",  32'(done1),    32'h1);
        check_eq("sw_c1_stall", 32'(stall1),   32'h0);
        next_cycle();
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        check_eq("sw_mem_lo", mem1[1], 32'h3344_AAAA);
        check_eq("sw_mem_hi", mem1[2], 32'hBBBB_1122);

        // Split LW wrapping the top of the address space, then back-to-back aligned load
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h0);
        @(negedge clk);
        check_eq("lw_wrap_c0_addr",  ram_addr1,   32'hFFFF_FFFC);
        check_eq("lw_wrap_c0_stall", 32'(stall1), 32'h1);
        next_cycle();
        @(negedge clk);
        check_eq("lw_wrap_c1_addr",  ram_addr1,   32'h0);
        check_eq("lw_wrap_c1_rdata", rdata1,      32'hCAFE_BEEF);
        check_eq("lw_wrap_c1_done",  32'(done1),  32'h1);
        next_cycle();
        drive(1'b1, 1'b0, 2'd3, 1'b0, 32'h20, 32'h0);
        @(negedge clk);
        check_eq("b2b_done",  32'(done1),    32'h1);
        check_eq("b2b_stall", 32'(stall1),   32'h0);
        check_eq("b2b_sel",   32'(ram_sel1), 32'hF);
        check_eq("b2b_rdata", rdata1,        32'h8001_1234);
        next_cycle();
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);

        // Reject on the non-splitting instance; abort on the splitting one
        preload(4'd0, 32'h5A5A_5A5A);
        drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h01, 32'hFFFF_FFFF);
        @(negedge clk);
        check_eq("rej_err",   32'(err2),    32'h1);
        check_eq("rej_done",  32'(done2),   32'h1);
        check_eq("rej_ce",    32'(ram_ce2), 32'h0);
        check_eq("rej_stall", 32'(stall2),  32'h0);
        check_eq("split_stall", 32'(stall1), 32'h1);
        next_cycle();
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check_eq("abort_ce",   32'(ram_ce1), 32'h0);
        check_eq("abort_done", 32'(done1),   32'h0);
        check_eq("rej_err_1cyc", 32'(err2),  32'h0);
        check_eq("rej_mem",    mem2[0], 32'h5A5A_5A5A);
        check_eq("abort_mem_lo", mem1[0], 32'hFFFF_FF5A);
        next_cycle();
        check_eq("abort_mem_hi", mem1[1], 32'h3344_AAAA);
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h01, 32'h0);
        @(negedge clk);
        check_eq("rej_lw_err", 32'(err2),    32'h1);
        check_eq("rej_lw_ce",  32'(ram_ce2), 32'h0);
        next_cycle();
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        next_cycle();

        // Reset in the middle of a split store
        preload(4'd3, 32'h3333_3333);
        preload(4'd4, 32'h4444_4444);
        drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h0E, 32'h5566_7788);
        @(negedge clk);
        check_eq("mid_c0_addr",  ram_addr1,   32'h0C);
        check_eq("mid_c0_stall", 32'(stall1), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_ce",    32'(ram_ce1), 32'h0);
        check_eq("mid_rst_done",  32'(done1),   32'h0);
        check_eq("mid_rst_stall", 32'(stall1),  32'h0);
        check_eq("mid_rst_addr",  ram_addr1,    32'h0);
        check_eq("mid_rst_sel",   32'(ram_sel1), 32'h0);
        check_eq("mid_rst_wdata", ram_wdata1,   32'h0);
        next_cycle();
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        rst = 1'b0;
        check_eq("mid_mem_hi", mem1[4], 32'h4444_4444);
        check_eq("mid_mem_lo", mem1[3], 32'h7788_3333);
        next_cycle();
        drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
        @(negedge clk);
        check_eq("post_done",  32'(done1),    32'h1);
        check_eq("post_stall", 32'(stall1),   32'h0);
        check_eq("post_sel",   32'(ram_sel1), 32'hF);
        check_eq("post_addr",  ram_addr1,     32'h10);
        next_cycle();
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        check_eq("post_mem", mem1[4], 32'hDEAD_BEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Initiator side of the core's data-RAM port; sits in the MEM stage between the pipeline and the data RAM.
- Converts load/store requests (byte/half/word, signed/unsigned) into ce/we/addr/sel/data bus cycles on the 4-lane byte-select RAM interface.
- Returns aligned, sign/zero-extended load data to the pipeline.
- Misaligned accesses that straddle a word boundary are split into two word cycles by a small FSM. The pipeline is stalled for the first of those cycles.

Parameters:
- ADDR_W, 32, byte-address width of request and RAM address.
- MISALIGN_SPLIT, 1, 1 = split straddling accesses into two cycles; 0 = reject them with err and issue no bus cycle.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  MEM-stage access request; held stable by requester while stall_req=1.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 = reserved, treated as word.
- req_unsigned  in  1  1 = zero-extend load (LBU/LHU).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- rdata  out  32  extended load result, valid when done=1 and req_we=0.
- done  out  1  access completes this cycle.
- stall_req  out  1  hold pipeline; request must not change.
- err  out  1  misaligned reject (MISALIGN_SPLIT=0 only).
- ram_ce  out  1  RAM chip enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  word-aligned address; bits [1:0] are always 0.
- ram_sel  out  4  byte-lane enables; bit i covers data[8i+7:8i].
- ram_wdata  out  32  lane-positioned store data.
- ram_rdata  in  32  RAM read data, combinational, same cycle as address.

Behaviour:
- Reset (async): state=IDLE, hold_q=0. Outputs while idle: ram_ce=0, ram_we=0, ram_addr=0, ram_sel=0, ram_wdata=0, rdata=0, done=0, stall_req=0, err=0.
- Definitions:
  - off = req_addr[1:0].
  - nbytes = 1, 2 or 4 by req_size.
  - mask = 4'b0001, 4'b0011 or 4'b1111 by req_size.
  - straddle = off + nbytes > 4.
- IDLE, req_valid=1, no straddle (single cycle):
  - ram_ce=1, ram_we=req_we, ram_addr={req_addr[ADDR_W-1:2],2'b00}.
  - ram_sel = mask << off (4 LSBs kept).
  - ram_wdata = req_wdata << 8*off.
  - done=1 combinationally.
  - rdata = (ram_rdata >> 8*off), then sign- or zero-extended from bit 8*nbytes-1.
- IDLE, req_valid=1, straddle, MISALIGN_SPLIT=1 (first cycle of two):
  - Issue low word: sel = (mask << off)[3:0], ram_wdata = req_wdata << 8*off.
  - stall_req=1, done=0.
  - Loads latch ram_rdata >> 8*off into hold_q.
  - Next state SECOND.
- SECOND:
  - ram_addr = low word address + 4, modulo 2^ADDR_W; 0xFFFFFFFC wraps to 0x0.
  - ram_sel = (mask << off) >> 4.
  - ram_wdata = req_wdata >> 8*(4-off).
  - done=1, stall_req=0.
  - rdata = hold_q OR (ram_rdata << 8*(4-off)), then extended per size.
  - Next state IDLE.
- Straddle with MISALIGN_SPLIT=0: err=1 for one cycle, done=1, ram_ce=0, no write occurs.
- req_valid=0 in SECOND: abort to IDLE, ram_ce=0. A first-half store has already been written; this is not rolled back.
- Back-to-back: a new request is sampled only in IDLE; the cycle after SECOND may start a new access with no bubble.
- rst asserted mid-split: immediate return to IDLE; the second cycle is never issued.
- Reserved size 3: handled exactly as word.
- Latency: aligned = 0 extra cycles; straddling = 1 extra cycle.

Decomposition:
- bitty_defs.v gains: MemByte/MemHalf/MemWord size codes, FSM state codes (LsuIdle, LsuSecond), and ByteSelAll.
- One combinational sub-module, mem_lane_align: lane shift and sign/zero extension for load data. Instantiated once on the read path.
- Store shifting and the FSM stay in lsu_mem_master.

Test Plan:
1. SB addr 0x13, wdata 0xAB → one cycle: ram_addr 0x10, sel 4'b1000, ram_wdata 0xAB000000, done=1, stall_req=0.
2. LH signed addr 0x22, RAM word 0x8001xxxx → rdata 0xFFFF8001. Same with LHU → 0x00008001.
3. SW addr 0x06, wdata 0x11223344:
   - cycle 0: addr 0x04, sel 4'b1100, data 0x33440000, stall_req=1.
   - cycle 1: addr 0x08, sel 4'b0011, data 0x00001122, done=1.
   - RAM readback: word 0x04 upper half = 0x3344, word 0x08 lower half = 0x1122.
4. LW addr 0xFFFFFFFE, RAM[0xFFFFFFFC]=0xBEEFxxxx, RAM[0x0]=0xxxxxCAFE → second cycle at addr 0x0, rdata 0xCAFEBEEF.
5. MISALIGN_SPLIT=0, LW addr 0x01 → err=1, done=1, ram_ce=0, memory unchanged.
6. rst pulsed during SECOND of a split store → no second-cycle write; all outputs at reset values; next aligned SW completes in one cycle.
